// File: rtl/pio_led_blink_if.sv
// Avalon-MM slave bus bundle for the PIO LED blink peripheral.
// The master modport drives the address/strobe/data side; the slave
// modport returns combinational read data.
interface pio_led_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_led_blink.sv
// PIO LED output port with bit set/clear/toggle registers and an optional
// blink engine that periodically blanks the masked LEDs.
// Optional feature macro: PIO_LED_BLINK_EN (adds BLINK_MASK, BLINK_PERIOD,
// the prescaler and the phase bit). Without it, addresses 4-5 are unmapped
// and out_port is a plain copy of DATA.
// Register map (word addresses):
//   0 DATA (RW)   1 SET (W)   2 CLEAR (W)   3 TOGGLE (W)
//   4 BLINK_MASK (RW)   5 BLINK_PERIOD (RW)   6-7 unmapped
module pio_led_blink #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          PRESC_W     = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_led_blink_if.slave    bus,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_MASK   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;

    localparam logic [WIDTH-1:0] DATA_INIT = RESET_VALUE[WIDTH-1:0];

    logic             write_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;
    logic             unused_wdata;

    assign write_en     = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    // Bits above the register widths are ignored on writes by design.
    assign unused_wdata = ^bus.writedata;

    // Next DATA value: load, set, clear or toggle depending on the target address.
    always_comb begin
        data_next = data;
        if (write_en) begin
            case (bus.address)
                ADDR_DATA:   data_next = wdata;
                ADDR_SET:    data_next = data | wdata;
                ADDR_CLEAR:  data_next = data & ~wdata;
                ADDR_TOGGLE: data_next = data ^ wdata;
                default:     data_next = data;
            endcase
        end
    end

    // DATA register; reset wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data <= DATA_INIT;
        end else begin
            data <= data_next;
        end
    end

`ifdef PIO_LED_BLINK_EN
    logic [WIDTH-1:0]   mask;
    logic [PRESC_W-1:0] period;
    logic [PRESC_W-1:0] cnt;
    logic               phase;
    logic               mask_wr;
    logic               period_wr;

    assign mask_wr   = write_en && (bus.address == ADDR_MASK);
    assign period_wr = write_en && (bus.address == ADDR_PERIOD);

    // Blink configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask   <= '0;
            period <= '0;
        end else begin
            if (mask_wr) begin
                mask <= wdata;
            end
            if (period_wr) begin
                period <= bus.writedata[PRESC_W-1:0];
            end
        end
    end

    // Prescaler and phase: a period write restarts the count so a shorter period can never be overrun.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (period_wr) begin
            cnt <= '0;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Masked LEDs are blanked while phase is low.
    always_comb begin
        out_port = data & ~(mask & {WIDTH{~phase}});
    end

    // Combinational zero-extended read mux; write-only and unmapped addresses read 0.
    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = 32'(data);
            ADDR_MASK:   bus.readdata = 32'(mask);
            ADDR_PERIOD: bus.readdata = 32'(period);
            default:     bus.readdata = 32'h0;
        endcase
    end
`else
    logic [PRESC_W-1:0] unused_presc;

    assign unused_presc = '0;

    // Without the blink engine the LEDs follow DATA directly.
    always_comb begin
        out_port = data;
    end

    // Combinational zero-extended read mux; only DATA is readable.
    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            ADDR_DATA: bus.readdata = 32'(data);
            default:   bus.readdata = 32'h0;
        endcase
    end
`endif

endmodule

// File: tb/tb_pio_led_blink.sv
// Self-checking bench for pio_led_blink: a register/bit-op vector table,
// directed blink sequences (when PIO_LED_BLINK_EN is defined) or the
// blink-disabled checks otherwise, then randomized bus traffic compared
// against a behavioural model.
module tb_pio_led_blink;

    localparam int          WIDTH       = 8;
    localparam int          PRESC_W     = 24;
    localparam logic [31:0] RESET_VALUE = 32'h0000_00A5;
`ifdef PIO_LED_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;

    pio_led_blink_if bus_if();

    pio_led_blink #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RESET_VALUE),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if.slave),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: phase is derived from the number of edges since the
    // last anchor (reset or period write) rather than from a counter.
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    longint           m_period;
    longint           m_edges;
    bit               m_base;

    function automatic bit m_phase();
        return m_base ^ (((m_edges / (m_period + 1)) % 2) == 1);
    endfunction

    function automatic logic [WIDTH-1:0] m_out();
        if (BLINK_EN && !m_phase())
            return m_data & ~m_mask;
        return m_data;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] addr);
        logic [31:0] r;
        r = 32'h0;
        case (addr)
            3'd0: r = 32'(m_data);
            3'd4: r = BLINK_EN ? 32'(m_mask) : 32'h0;
            3'd5: r = BLINK_EN ? 32'(m_period) : 32'h0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_edge(input bit rn, input bit cs, input bit wn,
                              input logic [2:0] addr, input logic [31:0] wd);
        logic [31:0]      rv;
        logic [WIDTH-1:0] v;
        bit               wr;
        rv = RESET_VALUE;
        v  = wd[WIDTH-1:0];
        wr = cs && !wn;
        if (!rn) begin
            m_data   = rv[WIDTH-1:0];
            m_mask   = '0;
            m_period = 0;
            m_edges  = 0;
            m_base   = 1'b1;
        end else begin
            if (wr && BLINK_EN && addr == 3'd5) begin
                m_base   = m_phase();
                m_edges  = 0;
                m_period = longint'(wd) & ((longint'(1) << PRESC_W) - 1);
            end else begin
                m_edges++;
            end
            if (wr) begin
                case (addr)
                    3'd0: m_data = v;
                    3'd1: m_data = m_data | v;
                    3'd2: m_data = m_data & ~v;
                    3'd3: m_data = m_data ^ v;
                    3'd4: if (BLINK_EN) m_mask = v;
                    default: ;
                endcase
            end
        end
    endtask

    // Drive one bus cycle across a rising edge and advance the model with it.
    task automatic applyStimulus(input bit rn, input bit cs, input bit wn,
                                 input logic [2:0] addr, input logic [31:0] wd);
        reset_n             = rn;
        bus_if.chipselect   = cs;
        bus_if.write_n      = wn;
        bus_if.address      = addr;
        bus_if.writedata    = wd;
        @(posedge clk);
        model_edge(rn, cs, wn, addr, wd);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    // Present a read address and compare outputs on the falling edge.
    task automatic checkOutput(input string name, input logic [2:0] rd_addr,
                               input logic [WIDTH-1:0] exp_out, input logic [31:0] exp_rd);
        bus_if.address = rd_addr;
        @(negedge clk);
        vectors++;
        if (out_port !== exp_out) begin
            miscompares++;
            $display("[TB] FAIL %s out_port: got %h, expected %h", name, out_port, exp_out);
        end
        vectors++;
        if (bus_if.readdata !== exp_rd) begin
            miscompares++;
            $display("[TB] FAIL %s readdata@%0d: got %h, expected %h", name, rd_addr, bus_if.readdata, exp_rd);
        end
    endtask

    typedef struct {
        bit               rn;
        bit               cs;
        bit               wn;
        logic [2:0]       wa;
        logic [31:0]      wd;
        logic [2:0]       ra;
        logic [WIDTH-1:0] eo;
        logic [31:0]      er;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int          toggle_at;
        int          bad;
        logic [WIDTH-1:0] first;
        bit          rn;
        bit          cs;
        bit          wn;
        logic [2:0]  addr;
        logic [2:0]  ra;
        logic [31:0] wd;

        reset_n           = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_00FF, 3'd0, 8'hA5, 32'h0000_00A5};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_000F, 3'd0, 8'h0F, 32'h0000_000F};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_0030, 3'd0, 8'h3F, 32'h0000_003F};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0003, 3'd0, 8'h3C, 32'h0000_003C};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_00FF, 3'd0, 8'hC3, 32'h0000_00C3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0000, 3'd0, 8'hC3, 32'h0000_00C3};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, 3'd6, 8'hC3, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF, 3'd0, 8'hC3, 32'h0000_00C3};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3'd0, 32'h0000_0000, 3'd0, 8'hC3, 32'h0000_00C3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'hABCD_1255, 3'd0, 8'h55, 32'h0000_0055};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd1, 32'hFFFF_FF00, 3'd1, 8'h55, 32'h0000_0000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0050, 3'd3, 8'h05, 32'h0000_0000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_000A, 3'd2, 8'h0F, 32'h0000_0000};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_0000, 3'd0, 8'hA5, 32'h0000_00A5};

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].rn, tbl[i].cs, tbl[i].wn, tbl[i].wa, tbl[i].wd);
            checkOutput($sformatf("table[%0d]", i), tbl[i].ra, tbl[i].eo, tbl[i].er);
        end

`ifdef PIO_LED_BLINK_EN
        // Blink with period 3: four cycles blanked, four lit, starting blanked.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_00FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_0001);
        if (m_phase())
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'h0000_0003);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("blink[%0d]", i), 3'd5,
                        (((i / 4) % 2) == 0) ? 8'hFE : 8'hFF, 32'h0000_0003);
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        end

        // Shrinking the period mid-count restarts the count from zero.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'd100);
        repeat (50) applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'd10);
        checkOutput("period_rewrite_start", 3'd5, m_out(), 32'd10);
        first     = out_port;
        toggle_at = -1;
        for (int k = 1; k <= 200 && toggle_at < 0; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
            @(negedge clk);
            if (out_port !== first) toggle_at = k;
        end
        vectors++;
        if (toggle_at != 11) begin
            miscompares++;
            $display("[TB] FAIL period_rewrite toggle cycle: got %0d, expected 11", toggle_at);
        end
`else
        // Blink registers absent: mask/period writes are ignored and read 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_005A);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_00FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 32'h0000_0003);
        checkOutput("mask_unmapped", 3'd4, 8'h5A, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        checkOutput("period_unmapped", 3'd5, 8'h5A, 32'h0);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
            @(negedge clk);
            if (out_port !== 8'h5A) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL no_toggle cycles off DATA: got %0d, expected 0", bad);
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ra = 3'($urandom_range(0, 7));
            bus_if.chipselect = 1'($urandom_range(0, 1));
            checkOutput($sformatf("random[%0d]", i), ra, m_out(), m_rd(ra));
            rn   = ($urandom_range(0, 59) != 0);
            cs   = ($urandom_range(0, 3) != 0);
            wn   = ($urandom_range(0, 2) == 0);
            addr = 3'($urandom_range(0, 7));
            wd   = $urandom;
            if (addr == 3'd5)
                wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
            applyStimulus(rn, cs, wn, addr, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_led_blink.md
PIO_LED_BLINK -- requirements
Module: pio_led_blink

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the output port width in bits (legal 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the DATA register value after reset.
REQ-003 The block SHALL have parameter PRESC_W, default 24, meaning the blink prescaler counter and BLINK_PERIOD width in bits (legal 1..32).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 The block SHALL have port address, input, 3 bits, the Avalon-MM word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit, the slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit, the active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits, the write data.
REQ-010 The block SHALL have port readdata, output, 32 bits, the read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits, driving the LEDs.

Function
REQ-012 Register map: 0 DATA (RW), 1 SET (W), 2 CLEAR (W), 3 TOGGLE (W), 4 BLINK_MASK (RW), 5 BLINK_PERIOD (RW), 6-7 unmapped.
REQ-013 A write SHALL occur only on a cycle with chipselect=1 and write_n=0; only writedata[WIDTH-1:0] (PRESC_W bits for BLINK_PERIOD) is used, and the upper bits are ignored.
REQ-014 Write effects on DATA, visible the cycle after the write edge: DATA writes load the value; SET ORs it in; CLEAR clears the bits set in writedata; TOGGLE XORs it.
REQ-015 readdata SHALL be combinational (read latency 0, no wait states) and zero-extended: DATA, BLINK_MASK and BLINK_PERIOD read back their values; SET, CLEAR, TOGGLE and unmapped addresses read 0.
REQ-016 readdata SHALL NOT depend on chipselect, and reads SHALL have no side effects.
REQ-017 Blink engine: prescaler cnt increments each cycle; when cnt==BLINK_PERIOD, cnt wraps to 0 and phase inverts on the same edge, so phase toggles every BLINK_PERIOD+1 cycles (BLINK_PERIOD=0 means it toggles every cycle).
REQ-018 A write to BLINK_PERIOD SHALL clear cnt to 0 on that edge and leave phase unchanged; this takes priority over the wrap in the same cycle.
REQ-019 If BLINK_PERIOD is written to a value below the current cnt, the clear in REQ-018 SHALL prevent any overrun; cnt SHALL never exceed BLINK_PERIOD.
REQ-020 out_port SHALL equal DATA & ~(BLINK_MASK & {WIDTH{~phase}}), registered-free, i.e. combinational from the registers.
REQ-021 A DATA or mask update and a phase toggle on the same edge SHALL both take effect.
REQ-022 Writes to unmapped addresses SHALL have no effect.

Reset
REQ-023 While reset_n=0 at a clk edge, the block SHALL set DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, cnt=0 and phase=1.
REQ-024 After reset, out_port SHALL equal RESET_VALUE[WIDTH-1:0]; reset SHALL override any simultaneous write.
REQ-025 Reset asserted mid-blink SHALL abort the count, and counting SHALL restart from 0 on the first edge with reset_n=1.

Configuration
REQ-026 Macro PIO_LED_BLINK_EN defined: the blink engine, BLINK_MASK and BLINK_PERIOD SHALL be implemented as specified above.
REQ-027 PIO_LED_BLINK_EN undefined: no prescaler, phase or mask logic; addresses 4-5 SHALL behave as unmapped (read 0, writes ignored), and out_port SHALL equal DATA.

Verification
REQ-028 Reset: RESET_VALUE=8'hA5, hold reset_n=0 while writing DATA=8'hFF -> out_port=8'hA5, and readdata at address 0 = 32'h000000A5.
REQ-029 Bit ops: write DATA=8'h0F, SET 8'h30, CLEAR 8'h03, TOGGLE 8'hFF -> DATA reads 8'h0F, 8'h3F, 8'h3C, 8'hC3.
REQ-030 Blink: DATA=8'hFF, BLINK_MASK=8'h01, BLINK_PERIOD=3 -> out_port alternates 8'hFF/8'hFE every 4 cycles, starting with 4 cycles of 8'hFE after the PERIOD write.
REQ-031 Period rewrite: PERIOD=100, wait 50 cycles, write PERIOD=10 -> next phase toggle occurs exactly 11 cycles after that write, with no 2^PRESC_W overrun.
REQ-032 Ignored writes: chipselect=0 write to address 0, and a write of 32'hFFFFFFFF to address 6 -> DATA unchanged, and address 6 reads 0.
REQ-033 Macro off: write BLINK_MASK=8'hFF, then read address 4 -> returns 0, and out_port equals DATA with no toggling over 1000 cycles.
